// File: rtl/nn_vector_stream_source_if.sv
// Bus bundle for the vector stream source: a wide vector load port on one
// side and an element-wide valid/ready stream on the other.
// master: the stream source itself; slave: whoever feeds vectors and
// consumes elements.
interface nn_vector_stream_source_if #(
  parameter int N     = 8,
  parameter int WIDTH = 16,
  parameter int LOGN  = 3
);
  logic                    vec_valid;
  logic                    vec_ready;
  logic [N*WIDTH-1:0]      vec_in;
  logic                    m_valid;
  logic                    m_ready;
  logic signed [WIDTH-1:0] data_out;
  logic                    m_last;
  logic [LOGN-1:0]         elem_idx;
  logic [15:0]             vec_sent;

  modport master (
    input  vec_valid, vec_in, m_ready,
    output vec_ready, m_valid, data_out, m_last, elem_idx, vec_sent
  );

  modport slave (
    output vec_valid, vec_in, m_ready,
    input  vec_ready, m_valid, data_out, m_last, elem_idx, vec_sent
  );
endinterface

// File: rtl/nn_vector_stream_source.sv
// Vector-to-element stream source. Whole vectors land in a two-slot
// ping-pong buffer; the oldest buffered vector is sent one element per
// accepted transfer, element 0 first. Loading into the free slot while the
// other slot drains lets consecutive vectors stream without a bubble.
module nn_vector_stream_source #(
  parameter int N     = 8,
  parameter int WIDTH = 16,
  parameter int LOGN  = 3
) (
  input logic                       clk,
  input logic                       reset,
  nn_vector_stream_source_if.master bus
);

  // Slot storage carries no reset: count alone says which slots are live.
  logic [N*WIDTH-1:0] slot_mem [2];

  logic            wr_ptr_reg;
  logic            rd_ptr_reg;
  logic [1:0]      count_reg;
  logic [LOGN-1:0] idx_reg;
  logic [15:0]     vec_sent_reg;

  logic               load;
  logic               xfer;
  logic               last_elem;
  logic               vec_done;
  logic [1:0]         count_next;
  logic [N*WIDTH-1:0] cur_vec;
  logic [WIDTH-1:0]   elems [N];

  // Split the vector being drained into addressable elements.
  assign cur_vec = slot_mem[rd_ptr_reg];
  for (genvar gi = 0; gi < N; gi++) begin : g_elem
    assign elems[gi] = cur_vec[gi*WIDTH +: WIDTH];
  end

  // Handshakes and stream outputs; all are functions of registers (and
  // reset) only, so nothing here combinationally follows m_ready/vec_valid.
  always_comb begin
    bus.vec_ready = !reset && (count_reg != 2'd2);
    bus.m_valid   = !reset && (count_reg != 2'd0);
    last_elem     = (idx_reg == LOGN'(N - 1));
    bus.m_last    = bus.m_valid && last_elem;
    bus.data_out  = bus.m_valid ? elems[idx_reg] : '0;
    bus.elem_idx  = idx_reg;
    bus.vec_sent  = vec_sent_reg;
    load          = bus.vec_valid && bus.vec_ready;
    xfer          = bus.m_valid && bus.m_ready;
    vec_done      = xfer && last_elem;
  end

  // Occupancy: a load and a vector completion on the same edge cancel out.
  always_comb begin
    count_next = count_reg;
    case ({load, vec_done})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
  end

  // Capture an incoming vector into the free slot (load implies not reset).
  always_ff @(posedge clk) begin
    if (load) begin
      slot_mem[wr_ptr_reg] <= bus.vec_in;
    end
  end

  // Pointer, element index, occupancy and completed-vector counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg   <= 1'b0;
      rd_ptr_reg   <= 1'b0;
      count_reg    <= 2'd0;
      idx_reg      <= '0;
      vec_sent_reg <= 16'd0;
    end else begin
      count_reg <= count_next;
      if (load) begin
        wr_ptr_reg <= ~wr_ptr_reg;
      end
      if (xfer) begin
        if (last_elem) begin
          idx_reg      <= '0;
          rd_ptr_reg   <= ~rd_ptr_reg;
          vec_sent_reg <= vec_sent_reg + 16'd1;
        end else begin
          idx_reg <= idx_reg + LOGN'(1);
        end
      end
    end
  end

endmodule
